// File: rtl/flip_flop_fifo_with_status_flags.sv
// Flop-array FIFO of arbitrary depth (>= 2) with registered status flags,
// an occupancy count and sticky overflow/underflow error flags.
// Every status output is a flop loaded from count_next, so consumers see no
// combinational path through the count arithmetic.
module flip_flop_fifo_with_status_flags #(
  parameter int width                         = 8,
  parameter int depth                         = 5,
  parameter int almost_full_level             = depth - 1,
  parameter int almost_empty_level            = 1,
  parameter int allow_push_when_full_with_pop = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             write_data,
  input  logic                         clear_errors,
  output logic [width-1:0]             read_data,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int cw = $clog2(depth + 1);
  localparam int pw = $clog2(depth);
  localparam logic allow_full_push = (allow_push_when_full_with_pop != 0);

  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [cw-1:0] af_lvl  = cw'(almost_full_level);
  localparam logic [cw-1:0] ae_lvl  = cw'(almost_empty_level);
  localparam logic [pw-1:0] last_ix = pw'(depth - 1);

  // Elaboration-time guard on the parameter ranges.
  if (depth < 2) begin : g_bad_depth
    $error("flip_flop_fifo_with_status_flags: depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
    $error("flip_flop_fifo_with_status_flags: almost_full_level out of range");
  end
  if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ae
    $error("flip_flop_fifo_with_status_flags: almost_empty_level out of range");
  end

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [cw-1:0]    count_next;

  // Explicit wrap at depth-1; depth need not be a power of two, so the
  // pointers never alias and are never compared to derive full/empty.
  function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
    return (p == last_ix) ? '0 : p + pw'(1);
  endfunction

  // Effective operations: pops on empty and blocked pushes are ignored.
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | (allow_full_push & pop));
    count_next = count + cw'(do_push) - cw'(do_pop);
  end

  // Head entry straight from the flop array; don't-care while empty.
  assign read_data = mem[rd_ptr];

  // Storage is deliberately not reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= write_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  // Status flags registered from count_next so they move with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      empty        <= (count_next == '0);
      full         <= (count_next == depth_c);
      almost_empty <= (count_next <= ae_lvl);
      almost_full  <= (count_next >= af_lvl);
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push & ~do_push) | (overflow & ~clear_errors);
      underflow <= (pop & empty)     | (underflow & ~clear_errors);
    end
  end

endmodule

// File: tb/tb_flip_flop_fifo_with_status_flags.sv
// Bench for flip_flop_fifo_with_status_flags: two instances (index = value of
// allow_push_when_full_with_pop) share stimulus; a queue model per instance
// supplies the expected count, flags and head data.
module tb_flip_flop_fifo_with_status_flags;

  localparam int DEPTH = 5;
  localparam logic [8:0] RST_ST = 9'b1_0_1_0_0_0_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [7:0] wd = '0;

  logic [7:0] rd  [2];
  logic [2:0] cnt [2];
  logic       emp [2], ful [2], ae [2], af [2], ovf [2], unf [2];
  logic [8:0] st  [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq [2][$];
  bit         movf [2];
  bit         munf [2];

  always #5 clk = ~clk;

  flip_flop_fifo_with_status_flags #(.width(8), .depth(DEPTH),
    .allow_push_when_full_with_pop(0)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .write_data(wd),
    .clear_errors(clr), .read_data(rd[0]), .empty(emp[0]), .full(ful[0]),
    .almost_empty(ae[0]), .almost_full(af[0]), .count(cnt[0]),
    .overflow(ovf[0]), .underflow(unf[0]));

  flip_flop_fifo_with_status_flags #(.width(8), .depth(DEPTH),
    .allow_push_when_full_with_pop(1)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .write_data(wd),
    .clear_errors(clr), .read_data(rd[1]), .empty(emp[1]), .full(ful[1]),
    .almost_empty(ae[1]), .almost_full(af[1]), .count(cnt[1]),
    .overflow(ovf[1]), .underflow(unf[1]));

  assign st[0] = {emp[0], ful[0], ae[0], af[0], ovf[0], unf[0], cnt[0]};
  assign st[1] = {emp[1], ful[1], ae[1], af[1], ovf[1], unf[1], cnt[1]};

  // Expected {empty,full,almost_empty,almost_full,overflow,underflow,count}.
  function automatic logic [8:0] exp_st(input int a);
    int n;
    n = mq[a].size();
    return {n == 0, n == DEPTH, n <= 1, n >= DEPTH - 1, movf[a], munf[a], 3'(n)};
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      mq[a].delete();
      movf[a] = 0;
      munf[a] = 0;
    end
  endtask

  // Drive one cycle, advance the model from pre-edge state, settle 1ns past the edge.
  task automatic step(input bit p, input bit o, input logic [7:0] d, input bit c);
    push = p; pop = o; wd = d; clr = c;
    @(posedge clk);
    for (int a = 0; a < 2; a++) begin
      int n;
      bit dpop, dpush;
      n     = mq[a].size();
      dpop  = o && n > 0;
      dpush = p && (n < DEPTH || (a == 1 && o));
      movf[a] = (p && !dpush) || (movf[a] && !c);
      munf[a] = (o && n == 0) || (munf[a] && !c);
      if (dpop)  void'(mq[a].pop_front());
      if (dpush) mq[a].push_back(d);
    end
    #1;
    push = 0; pop = 0; clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (st[a] !== RST_ST) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %b expected %b", a, st[a], RST_ST);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'(i * 17), 0);
      n_cmp++;
      if (cnt[1] !== 3'(i + 1) || ae[1] !== (i == 0) || af[1] !== (i >= 3) ||
          ful[1] !== (i == 4)) begin
        n_bad++;
        $display("FAIL fill_flags push%0d: got cnt=%0d ae=%b af=%b full=%b expected cnt=%0d ae=%b af=%b full=%b",
                 i + 1, cnt[1], ae[1], af[1], ful[1], i + 1, i == 0, i >= 3, i == 4);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (rd[1] !== 8'(i * 17)) begin
        n_bad++;
        $display("FAIL drain_data pop%0d: got %h expected %h", i + 1, rd[1], 8'(i * 17));
      end
      step(0, 1, 8'h00, 0);
    end
    n_cmp++;
    if (emp[1] !== 1'b1 || st[1] !== exp_st(1)) begin
      n_bad++;
      $display("FAIL drain_empty: got %b expected %b", st[1], exp_st(1));
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp1 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i * 17), 0);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (rd[a] !== 8'h00 || ful[a] !== 1'b1) begin
        n_bad++;
        $display("FAIL full_head dut%0d: got rd=%h full=%b expected rd=00 full=1", a, rd[a], ful[a]);
      end
    end
    step(1, 1, 8'h55, 0);
    n_cmp++;
    if (cnt[1] !== 3'd5 || ovf[1] !== 1'b0 || rd[1] !== 8'h11) begin
      n_bad++;
      $display("FAIL full_pushpop_allow1: got cnt=%0d ovf=%b rd=%h expected cnt=5 ovf=0 rd=11", cnt[1], ovf[1], rd[1]);
    end
    n_cmp++;
    if (cnt[0] !== 3'd4 || ovf[0] !== 1'b1 || rd[0] !== 8'h11) begin
      n_bad++;
      $display("FAIL full_pushpop_allow0: got cnt=%0d ovf=%b rd=%h expected cnt=4 ovf=1 rd=11", cnt[0], ovf[0], rd[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (rd[1] !== exp1[i]) begin
        n_bad++;
        $display("FAIL full_drain_allow1 pop%0d: got %h expected %h", i, rd[1], exp1[i]);
      end
      if (i < 4) begin
        n_cmp++;
        if (rd[0] !== exp1[i]) begin
          n_bad++;
          $display("FAIL full_drain_allow0 pop%0d: got %h expected %h", i, rd[0], exp1[i]);
        end
      end
      step(0, 1, 8'h00, 0);
      for (int a = 0; a < 2; a++) begin
        n_cmp++;
        if (st[a] !== exp_st(a)) begin
          n_bad++;
          $display("FAIL full_drain_status dut%0d: got %b expected %b", a, st[a], exp_st(a));
        end
      end
    end
    step(0, 0, 8'h00, 1);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (ovf[a] !== 1'b0 || unf[a] !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_errors dut%0d: got ovf=%b unf=%b expected 0 0", a, ovf[a], unf[a]);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(0, 1, 8'h00, 0);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (unf[a] !== 1'b1 || cnt[a] !== 3'd0 || emp[a] !== 1'b1) begin
        n_bad++;
        $display("FAIL underflow_set dut%0d: got unf=%b cnt=%0d expected unf=1 cnt=0", a, unf[a], cnt[a]);
      end
    end
    step(1, 1, 8'hAA, 0);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (cnt[a] !== 3'd1 || rd[a] !== 8'hAA || unf[a] !== 1'b1) begin
        n_bad++;
        $display("FAIL pushpop_empty dut%0d: got cnt=%0d rd=%h unf=%b expected cnt=1 rd=aa unf=1", a, cnt[a], rd[a], unf[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 0, 8'($urandom), 0);
    step(1, 0, 8'($urandom), 0);
    for (int i = 0; i < 25; i++) begin
      step(1, 1, 8'($urandom), 0);
      for (int a = 0; a < 2; a++) begin
        n_cmp++;
        if (cnt[a] !== 3'd2 || rd[a] !== mq[a][0] || st[a] !== exp_st(a)) begin
          n_bad++;
          $display("FAIL back_to_back dut%0d cyc%0d: got cnt=%0d rd=%h st=%b expected cnt=2 rd=%h st=%b",
                   a, i, cnt[a], rd[a], st[a], mq[a][0], exp_st(a));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 8'hC0 + 8'(i), 0);
    #2;
    rst_n = 0;
    #1;
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (st[a] !== RST_ST) begin
        n_bad++;
        $display("FAIL async_reset dut%0d: got %b expected %b", a, st[a], RST_ST);
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(0, 1, 8'h00, 0);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (unf[a] !== 1'b1 || cnt[a] !== 3'd0) begin
        n_bad++;
        $display("FAIL post_reset_pop dut%0d: got unf=%b cnt=%0d expected unf=1 cnt=0", a, unf[a], cnt[a]);
      end
    end
    step(1, 0, 8'h77, 0);
    for (int a = 0; a < 2; a++) begin
      n_cmp++;
      if (rd[a] !== 8'h77) begin
        n_bad++;
        $display("FAIL post_reset_data dut%0d: got %h expected 77", a, rd[a]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int pw;
      bit p, o, c;
      pw = ((i / 75) % 2 == 0) ? 75 : 30;
      p = ($urandom_range(99) < pw);
      o = ($urandom_range(99) < 100 - pw);
      c = ($urandom_range(15) == 0);
      step(p, o, 8'($urandom), c);
      for (int a = 0; a < 2; a++) begin
        n_cmp++;
        if (st[a] !== exp_st(a)) begin
          n_bad++;
          $display("FAIL random_status dut%0d cyc%0d: got %b expected %b", a, i, st[a], exp_st(a));
        end
        if (mq[a].size() > 0) begin
          n_cmp++;
          if (rd[a] !== mq[a][0]) begin
            n_bad++;
            $display("FAIL random_data dut%0d cyc%0d: got %h expected %h", a, i, rd[a], mq[a][0]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
